// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_e;

    // Slot that follows s; wraps 3 -> 0 to line up with the next frame.
    function automatic slot_t next_slot(input slot_t s);
        return slot_t'(s + 2'd1);
    endfunction

endpackage

// File: rtl/demux1x2.sv
// 1:2 enable demultiplexer: routes en to y0 (sel=0) or y1 (sel=1).
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: en - enable in; sel - select; y0/y1 - steered enables.
module demux1x2 (
    input  logic en,
    input  logic sel,
    output logic y0,
    output logic y1
);

    assign y0 = en & ~sel;
    assign y1 = en &  sel;

endmodule

// File: rtl/tdm_demux1x4.sv
// TDM receive demultiplexer: collects slots 0..3 into a 4-lane word, emits it atomically.
// Latency: dout/dout_valid registered at the edge sampling the slot-3 beat (visible next cycle).
// Backpressure: none; beats are accepted every cycle, gaps (din_valid=0) hold all state.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   din, din_valid    - slot sample and its beat qualifier
//   sof               - beat is slot 0 (only meaningful with din_valid)
//   dout, dout_valid  - last complete frame (lane k = dout[k*W +: W]) and its 1-cycle pulse
//   slot, busy        - next expected slot index, frame partially collected
//   err               - only when TDM_DEMUX_ERR_EN is defined: 1-cycle pulse after a
//                       truncated frame or a non-sof beat dropped in IDLE
module tdm_demux1x4
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           din,
    input  logic                   din_valid,
    input  logic                   sof,
    output logic [NUM_SLOTS*W-1:0] dout,
    output logic                   dout_valid,
    output slot_t                  slot,
    output logic                   busy
`ifdef TDM_DEMUX_ERR_EN
    ,
    output logic                   err
`endif
);

    tdm_state_e           state;
    logic [W-1:0]         shadow [NUM_SLOTS-1];
    logic                 wr_en;
    slot_t                wr_idx;
    logic                 en_lo;
    logic                 en_hi;
    logic [NUM_SLOTS-1:0] we;

    // A beat is written when it starts a frame (sof, any state) or continues
    // one in COLLECT. An sof beat always lands in slot 0 regardless of slot.
    assign wr_en  = din_valid & (sof | (state == COLLECT));
    assign wr_idx = sof ? slot_t'(0) : slot;

    demux1x2 u_root (.en(wr_en), .sel(wr_idx[1]), .y0(en_lo),  .y1(en_hi));
    demux1x2 u_lo   (.en(en_lo), .sel(wr_idx[0]), .y0(we[0]),  .y1(we[1]));
    demux1x2 u_hi   (.en(en_hi), .sel(wr_idx[0]), .y0(we[2]),  .y1(we[3]));

    // Slot 3 never needs storage: it goes straight into dout together with
    // the three shadowed lanes, so lanes always come from a single frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) shadow[i] <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                if (we[i]) shadow[i] <= din;
            end
            if (we[NUM_SLOTS-1]) begin
                dout       <= {din, shadow[2], shadow[1], shadow[0]};
                dout_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            slot  <= '0;
        end else if (din_valid) begin
            if (sof) begin
                // Fresh frame, or restart discarding a partial one.
                state <= COLLECT;
                slot  <= slot_t'(1);
            end else if (state == COLLECT) begin
                slot <= next_slot(slot);
                if (slot == slot_t'(NUM_SLOTS - 1)) state <= IDLE;
            end
        end
    end

    assign busy = (state == COLLECT);

`ifdef TDM_DEMUX_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= din_valid & (sof ? (state == COLLECT) : (state == IDLE));
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux1x4.sv
// Self-checking bench for tdm_demux1x4 (W=4): vector table, reset corner case,
// and randomized beats against a queue-based frame model.
module tb_tdm_demux1x4;

    localparam int W = 4;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  din;
    logic          din_valid;
    logic          sof;
    logic [4*W-1:0] dout;
    logic          dout_valid;
    logic [1:0]    slot;
    logic          busy;
`ifdef TDM_DEMUX_ERR_EN
    logic          err;
`endif

    tdm_demux1x4 #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .busy       (busy)
`ifdef TDM_DEMUX_ERR_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a frame is just a list of collected samples.
    logic [W-1:0]   mq[$];
    bit             m_in;
    logic [4*W-1:0] m_dout;
    bit             m_valid;
    bit             m_err;

    task automatic model_reset();
        mq.delete();
        m_in = 0; m_dout = '0; m_valid = 0; m_err = 0;
    endtask

    task automatic model_beat(input bit v, input bit s, input logic [W-1:0] d);
        m_valid = 0;
        m_err   = 0;
        if (v) begin
            if (s) begin
                m_err = m_in;
                mq.delete();
                mq.push_back(d);
                m_in = 1;
            end else if (m_in) begin
                mq.push_back(d);
                if (mq.size() == 4) begin
                    m_dout  = {mq[3], mq[2], mq[1], mq[0]};
                    m_valid = 1;
                    m_in    = 0;
                    mq.delete();
                end
            end else begin
                m_err = 1;
            end
        end
    endtask

    // Drive one cycle: inputs applied away from the edge, outputs sampled #1 after it.
    task automatic step(input bit v, input bit s, input logic [W-1:0] d);
        din_valid = v; sof = s; din = d;
        @(posedge clk);
        model_beat(v, s, d);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".dout"},       32'(dout),       32'(m_dout));
        chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
        chk({tag, ".slot"},       32'(slot),       m_in ? 32'(mq.size()) : 32'd0);
        chk({tag, ".busy"},       32'(busy),       32'(m_in));
`ifdef TDM_DEMUX_ERR_EN
        chk({tag, ".err"},        32'(err),        32'(m_err));
`endif
    endtask

    typedef struct {
        bit          v;
        bit          s;
        logic [3:0]  d;
        logic [15:0] e_dout;
        bit          e_valid;
        logic [1:0]  e_slot;
        bit          e_busy;
        bit          e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v, input bit s, input logic [3:0] d, input logic [15:0] ed,
                       input bit ev, input logic [1:0] es, input bit eb, input bit ee);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.e_dout = ed; t.e_valid = ev;
        t.e_slot = es; t.e_busy = eb; t.e_err = ee;
        tbl.push_back(t);
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; sof = 1'b0;
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame, back-to-back frame, idle drop, truncation, sof on slot-3 position.
        add(1,1,4'h1, 16'h0000,0,2'd1,1,0);
        add(1,0,4'h2, 16'h0000,0,2'd2,1,0);
        add(1,0,4'h3, 16'h0000,0,2'd3,1,0);
        add(1,0,4'h4, 16'h4321,1,2'd0,0,0);
        add(1,1,4'h5, 16'h4321,0,2'd1,1,0);
        add(1,0,4'h6, 16'h4321,0,2'd2,1,0);
        add(1,0,4'h7, 16'h4321,0,2'd3,1,0);
        add(1,0,4'h8, 16'h8765,1,2'd0,0,0);
        add(0,0,4'h0, 16'h8765,0,2'd0,0,0);
        add(1,0,4'hF, 16'h8765,0,2'd0,0,1);
        add(1,0,4'hE, 16'h8765,0,2'd0,0,1);
        add(1,1,4'h1, 16'h8765,0,2'd1,1,0);
        add(1,0,4'h2, 16'h8765,0,2'd2,1,0);
        add(1,1,4'h9, 16'h8765,0,2'd1,1,1);
        add(0,0,4'h0, 16'h8765,0,2'd1,1,0);
        add(1,0,4'hA, 16'h8765,0,2'd2,1,0);
        add(0,1,4'h7, 16'h8765,0,2'd2,1,0);
        add(1,0,4'hB, 16'h8765,0,2'd3,1,0);
        add(1,0,4'hC, 16'hCBA9,1,2'd0,0,0);
        add(1,1,4'h1, 16'hCBA9,0,2'd1,1,0);
        add(1,0,4'h2, 16'hCBA9,0,2'd2,1,0);
        add(1,0,4'h3, 16'hCBA9,0,2'd3,1,0);
        add(1,1,4'h4, 16'hCBA9,0,2'd1,1,1);
        add(1,0,4'h5, 16'hCBA9,0,2'd2,1,0);
        add(1,0,4'h6, 16'hCBA9,0,2'd3,1,0);
        add(1,0,4'h7, 16'h7654,1,2'd0,0,0);
        add(0,0,4'h0, 16'h7654,0,2'd0,0,0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d);
            chk($sformatf("vec%0d.dout", i),       32'(dout),       32'(tbl[i].e_dout));
            chk($sformatf("vec%0d.dout_valid", i), 32'(dout_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d.slot", i),       32'(slot),       32'(tbl[i].e_slot));
            chk($sformatf("vec%0d.busy", i),       32'(busy),       32'(tbl[i].e_busy));
`ifdef TDM_DEMUX_ERR_EN
            chk($sformatf("vec%0d.err", i),        32'(err),        32'(tbl[i].e_err));
`endif
        end

        // Reset after the slot-2 beat: outputs clear immediately, next frame completes.
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 0, 4'h3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("midrst");
        @(posedge clk); #1;
        check_model("midrst_hold");
        rst_n = 1'b1;
        step(1, 1, 4'h1); check_model("post_rst0");
        step(1, 0, 4'h2); check_model("post_rst1");
        step(1, 0, 4'h3); check_model("post_rst2");
        step(1, 0, 4'h4); check_model("post_rst3");
        chk("post_rst.dout", 32'(dout), 32'h4321);
        step(0, 0, 4'h0); check_model("post_rst_gap");

        // Random beats: mostly well-formed frames with 0-3 gaps, some stray sof/non-sof beats.
        for (int f = 0; f < 300; f++) begin
            int kind;
            kind = $urandom_range(0, 9);
            for (int b = 0; b < 4; b++) begin
                int gaps;
                bit s;
                gaps = $urandom_range(0, 3);
                for (int g = 0; g < gaps; g++) begin
                    step(0, 1'($urandom_range(0, 1)), 4'($urandom));
                    check_model("rnd_gap");
                end
                s = (b == 0) ? (kind != 0) : (kind == 1 && $urandom_range(0, 3) == 0);
                step(1, s, 4'($urandom));
                check_model("rnd_beat");
            end
        end
        step(0, 0, 4'h0);
        check_model("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
